// File: rtl/psg_core_if.sv
// rtl/psg_core_if.sv - host byte-write bus between CPU and psg_core
interface psg_core_if;
  logic       nWE;
  logic       nCE;
  logic [7:0] D;
  logic       READY;

  modport master (output nWE, output nCE, output D, input READY);
  modport slave  (input nWE, input nCE, input D, output READY);
endinterface

// File: rtl/psg_core.sv
// rtl/psg_core.sv - SN76489-style sound generator: latch/data write port,
// NUM_TONE square-wave tone channels and one LFSR noise channel
module psg_core #(
  parameter int                NUM_TONE  = 3,
  parameter int                PRESCALE  = 16,
  parameter int                WAIT_CYC  = 2,
  parameter int                LFSR_W    = 15,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 15'h0003
) (
  input  logic                      CLK,
  input  logic                      nRST,
  psg_core_if.slave                 bus,
  output logic [NUM_TONE-1:0]       tone_out,
  output logic                      noise_out,
  output logic [4*(NUM_TONE+1)-1:0] vol_out
);

  localparam int                PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int                WW   = $clog2(WAIT_CYC + 1);
  localparam logic [LFSR_W-1:0] SEED = {1'b1, {(LFSR_W-1){1'b0}}};
  localparam logic [2:0]        NT   = 3'(NUM_TONE);

  logic              wr, wr_q, accept;
  logic [WW-1:0]     wait_cnt;
  logic [1:0]        latch_ch;
  logic              latch_vol;
  logic [1:0]        tgt_ch;
  logic              tgt_vol, tgt_tone_ch, tgt_valid;
  logic              wr_vol, wr_tone_lo, wr_tone_hi, wr_noise;
  logic [PW-1:0]     presc;
  logic              tick;
  logic              last_tog;
  logic [2:0]        noise_ctl;
  logic [3:0]        vol_n;
  logic [6:0]        ncnt, nreload;
  logic              nflop, nclk_ev, shift, fb;
  logic [LFSR_W-1:0] lfsr;

  // A write is an edge of the combined strobe; a held strobe never repeats.
  assign wr        = ~bus.nWE & ~bus.nCE;
  assign bus.READY = (wait_cnt == '0);
  assign accept    = wr & ~wr_q & bus.READY;

  // Latch bytes address directly; data bytes reuse the last latched target.
  assign tgt_ch      = bus.D[7] ? bus.D[6:5] : latch_ch;
  assign tgt_vol     = bus.D[7] ? bus.D[4]   : latch_vol;
  assign tgt_tone_ch = ({1'b0, tgt_ch} < NT);
  assign tgt_valid   = tgt_tone_ch || (tgt_ch == 2'd3);
  assign wr_vol      = accept & tgt_vol & tgt_valid;
  assign wr_noise    = accept & ~tgt_vol & (tgt_ch == 2'd3);
  assign wr_tone_lo  = accept & ~tgt_vol & bus.D[7] & tgt_tone_ch;
  assign wr_tone_hi  = accept & ~tgt_vol & ~bus.D[7] & tgt_tone_ch;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_q      <= 1'b0;
      wait_cnt  <= '0;
      latch_ch  <= 2'd0;
      latch_vol <= 1'b0;
    end else begin
      wr_q <= wr;
      if (accept)
        wait_cnt <= WW'(WAIT_CYC);
      else if (wait_cnt != '0)
        wait_cnt <= wait_cnt - WW'(1);
      if (accept && bus.D[7]) begin
        latch_ch  <= bus.D[6:5];
        latch_vol <= bus.D[4];
      end
    end
  end

  assign tick = (presc == PW'(PRESCALE - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      presc <= '0;
    else
      presc <= tick ? '0 : presc + PW'(1);
  end

  for (genvar c = 0; c < NUM_TONE; c++) begin : g_tone
    logic [9:0] period, cnt;
    logic       sq, sel, tog;
    logic [3:0] vol;

    assign sel = (tgt_ch == 2'(c));
    assign tog = tick && (period > 10'd1) && (cnt <= 10'd1);

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        period <= '0;
        cnt    <= '0;
        sq     <= 1'b0;
        vol    <= 4'hF;
      end else begin
        if (wr_tone_lo && sel) period[3:0] <= bus.D[3:0];
        if (wr_tone_hi && sel) period[9:4] <= bus.D[5:0];
        if (wr_vol && sel)     vol         <= bus.D[3:0];
        // Period 0/1 parks the channel high rather than toggling at CLK/PRESCALE.
        if (tick && period <= 10'd1) begin
          cnt <= '0;
          sq  <= 1'b1;
        end else if (tog) begin
          cnt <= period;
          sq  <= ~sq;
        end else if (tick) begin
          cnt <= cnt - 10'd1;
        end
      end
    end

    assign tone_out[c]      = sq;
    assign vol_out[4*c +: 4] = vol;

    if (c == NUM_TONE - 1) begin : g_last
      assign last_tog = tog;
    end
  end

  assign vol_out[4*NUM_TONE +: 4] = vol_n;

  always_comb begin
    nreload = 7'd64;
    case (noise_ctl[1:0])
      2'd0:    nreload = 7'd16;
      2'd1:    nreload = 7'd32;
      default: nreload = 7'd64;
    endcase
  end

  assign nclk_ev   = (noise_ctl[1:0] == 2'd3) ? last_tog : (tick && ncnt <= 7'd1);
  assign shift     = nclk_ev & ~nflop;
  assign fb        = noise_ctl[2] ? ^(lfsr & LFSR_TAPS) : lfsr[0];
  assign noise_out = lfsr[0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      noise_ctl <= 3'd0;
      vol_n     <= 4'hF;
      ncnt      <= '0;
      nflop     <= 1'b0;
      lfsr      <= SEED;
    end else begin
      if (wr_noise)                   noise_ctl <= bus.D[2:0];
      if (wr_vol && tgt_ch == 2'd3)   vol_n     <= bus.D[3:0];
      if (tick)                       ncnt      <= (ncnt <= 7'd1) ? nreload : ncnt - 7'd1;
      if (nclk_ev)                    nflop     <= ~nflop;
      // A control write reseeds and swallows any shift due in the same cycle.
      if (wr_noise)
        lfsr <= SEED;
      else if (shift)
        lfsr <= {fb, lfsr[LFSR_W-1:1]};
    end
  end

endmodule

// File: tb/tb_psg_core.sv
// tb/tb_psg_core.sv - directed bench for psg_core: a 3-tone default instance
// and a 2-tone fast instance sharing one clock
module tb_psg_core;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  psg_core_if bus1 ();
  psg_core_if bus2 ();

  logic [2:0]  tone1;
  logic        noise1;
  logic [15:0] vol1;
  logic [1:0]  tone2;
  logic        noise2;
  logic [11:0] vol2;

  psg_core dut1 (
    .CLK(CLK), .nRST(nRST), .bus(bus1),
    .tone_out(tone1), .noise_out(noise1), .vol_out(vol1)
  );

  psg_core #(.NUM_TONE(2), .PRESCALE(2), .WAIT_CYC(1)) dut2 (
    .CLK(CLK), .nRST(nRST), .bus(bus2),
    .tone_out(tone2), .noise_out(noise2), .vol_out(vol2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input bit sel, input logic we_n, input logic [7:0] d);
    if (!sel) begin
      bus1.nWE = we_n; bus1.nCE = we_n; bus1.D = d;
    end else begin
      bus2.nWE = we_n; bus2.nCE = we_n; bus2.D = d;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus2.READY : bus1.READY;
  endfunction

  function automatic logic [14:0] lfsr_of(input bit sel);
    return sel ? dut2.lfsr : dut1.lfsr;
  endfunction

  function automatic logic [14:0] lfsr_next(input logic [14:0] v, input bit white);
    logic b;
    b = white ? (v[0] ^ v[1]) : v[0];
    return {b, v[14:1]};
  endfunction

  // One-cycle write strobe; READY must read low for exactly the wait count.
  task automatic wr_byte(input bit sel, input logic [7:0] d);
    int wc;
    wc = sel ? 1 : 2;
    drive(sel, 1'b0, d);
    step();
    drive(sel, 1'b1, d);
    for (int i = 0; i < wc; i++) begin
      chk("ready_low", rdy(sel), 1'b0);
      step();
    end
    chk("ready_high", rdy(sel), 1'b1);
  endtask

  task automatic noise_wr(input bit sel, input logic [7:0] d);
    drive(sel, 1'b0, d);
    step();
    drive(sel, 1'b1, d);
    chk("lfsr_reseed", lfsr_of(sel), 15'h4000);
  endtask

  task automatic tone_edge(output int n);
    logic prev;
    prev = tone1[0];
    n = 0;
    do begin step(); n++; end while (tone1[0] === prev && n < 5000);
  endtask

  task automatic track(input bit sel, input bit white, input int nshift, output int last_gap);
    logic [14:0] model, prev;
    int gap;
    model = 15'h4000;
    last_gap = 0;
    for (int k = 0; k < nshift; k++) begin
      prev = lfsr_of(sel);
      gap = 0;
      do begin step(); gap++; end while (lfsr_of(sel) == prev && gap < 2000);
      model = lfsr_next(model, white);
      chk("lfsr_seq", lfsr_of(sel), model);
      chk("noise_out", sel ? noise2 : noise1, model[0]);
      last_gap = gap;
    end
  endtask

  initial begin
    int n, lowcnt, gap;
    nRST = 1'b0;
    drive(0, 1'b1, 8'h00);
    drive(1, 1'b1, 8'h00);
    steps(3);
    nRST = 1'b1;
    step();
    chk("rst_ready", bus1.READY, 1'b1);
    chk("rst_tone", tone1, 3'b000);
    chk("rst_noise", noise1, 1'b0);
    chk("rst_vol", vol1, 16'hFFFF);
    chk("rst_lfsr", dut1.lfsr, 15'h4000);
    chk("rst_vol2", vol2, 12'hFFF);

    // ch0 period 0x0FE: half-period 254 ticks of 16 clocks
    wr_byte(0, 8'h8E);
    wr_byte(0, 8'h0F);
    tone_edge(n);
    tone_edge(n);
    tone_edge(n);
    chk("tone0_half1", n, 4064);
    tone_edge(n);
    chk("tone0_half2", n, 4064);
    chk("tone12_parked", tone1[2:1], 2'b11);

    wr_byte(0, 8'h95);
    chk("vol0_latch", vol1, 16'hFFF5);
    wr_byte(0, 8'h03);
    chk("vol0_data", vol1, 16'hFFF3);
    tone_edge(n);
    tone_edge(n);
    chk("tone0_kept", n, 4064);

    // strobe held for 10 cycles: one acceptance only
    lowcnt = 0;
    drive(0, 1'b0, 8'h97);
    for (int i = 0; i < 10; i++) begin step(); if (!bus1.READY) lowcnt++; end
    drive(0, 1'b1, 8'h97);
    for (int i = 0; i < 4; i++) begin step(); if (!bus1.READY) lowcnt++; end
    chk("hold_ready_low", lowcnt, 2);
    chk("hold_vol", vol1, 16'hFFF7);

    // strobe while busy is dropped
    drive(0, 1'b0, 8'h9A);
    step();
    drive(0, 1'b1, 8'h9A);
    step();
    chk("busy_ready", bus1.READY, 1'b0);
    drive(0, 1'b0, 8'h91);
    step();
    drive(0, 1'b1, 8'h91);
    steps(3);
    chk("busy_drop_vol", vol1, 16'hFFFA);
    chk("busy_ready_back", bus1.READY, 1'b1);

    wr_byte(0, 8'hF2);
    chk("noise_vol", vol1, 16'h2FFA);

    // white noise, rate 16: one shift per 32 ticks
    noise_wr(0, 8'hE4);
    track(0, 1'b1, 14, gap);
    chk("white_gap", gap, 512);
    chk("white_anchor", dut1.lfsr, 15'h4001);
    chk("white_bit", noise1, 1'b1);

    noise_wr(0, 8'hE0);
    track(0, 1'b0, 15, gap);
    chk("periodic_wrap", dut1.lfsr, 15'h4000);

    // two-tone instance: channel 2 writes are discarded, latch still moves
    wr_byte(1, 8'h90);
    wr_byte(1, 8'hC5);
    wr_byte(1, 8'h01);
    wr_byte(1, 8'hD3);
    wr_byte(1, 8'h01);
    chk("nt2_discard", vol2, 12'hFF0);

    // tone1 period 2 drives noise rate 3: shift every 8 clocks
    wr_byte(1, 8'hA2);
    wr_byte(1, 8'h00);
    noise_wr(1, 8'hE7);
    track(1, 1'b1, 6, gap);
    chk("nt2_tone_clocked_gap", gap, 8);

    // asynchronous reset in the middle of a write
    drive(0, 1'b0, 8'h90);
    step();
    chk("pre_rst_ready", bus1.READY, 1'b0);
    drive(0, 1'b1, 8'h90);
    #1 nRST = 1'b0;
    #1;
    chk("async_ready", bus1.READY, 1'b1);
    chk("async_vol", vol1, 16'hFFFF);
    chk("async_tone", tone1, 3'b000);
    chk("async_noise", noise1, 1'b0);
    chk("async_lfsr", dut1.lfsr, 15'h4000);
    chk("async_vol2", vol2, 12'hFFF);
    steps(2);
    nRST = 1'b1;
    steps(2);
    chk("post_rst_vol", vol1, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psg_core.md
# psg_core

Parametrised SN76489-compatible programmable sound generator core: CPU byte-write interface with latch/data protocol, up to three tone generators and one LFSR noise generator. Sits between the host write bus (nWE/nCE/D) and the mixer/DAC stage. Outputs per-channel square/noise bits and 4-bit attenuation values; mixing is downstream.

## Interface
Parameters:
- NUM_TONE, 3, number of tone channels (1..3); channel index 3 is always noise
- PRESCALE, 16, CLK cycles per generator tick (>=2)
- WAIT_CYC, 2, cycles READY stays low after an accepted write (>=1)
- LFSR_W, 15, noise shift register width (>=4)
- LFSR_TAPS, 15'h0003, XOR tap mask for white noise (bits ANDed with LFSR, reduced by XOR)

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous active-low
- nWE  in  1  write enable, active-low
- nCE  in  1  chip enable, active-low
- D  in  8  write data byte
- READY  out  1  high = write can be accepted
- tone_out  out  NUM_TONE  square wave per tone channel
- noise_out  out  1  noise bit (LFSR bit 0)
- vol_out  out  4*(NUM_TONE+1)  attenuation; channel n at [4n+3:4n], noise at top nibble; 4'hF = silent

## Operation
- Write request wr = ~nWE & ~nCE. Accepted on first cycle wr is high after a cycle with wr low, while READY=1. Held wr does not re-trigger; wr while READY=0 is dropped.
- Latch byte (D[7]=1): latched channel <= D[6:5], latched type <= D[4] (1=volume, 0=tone/noise).
  - type=1: vol[ch] <= D[3:0].
  - type=0, ch<NUM_TONE: tone[ch][3:0] <= D[3:0].
  - type=0, ch=3: noise_ctl <= D[2:0]; LFSR <= seed (1 << (LFSR_W-1)).
- Data byte (D[7]=0), targets latched register:
  - tone: tone[ch][9:4] <= D[5:0].
  - volume: vol[ch] <= D[3:0].
  - noise: noise_ctl <= D[2:0]; LFSR reseeded.
- Latched ch in NUM_TONE..2: latch state recorded, register writes discarded.
- Tone period 10 bits. Prescaler counts 0..PRESCALE-1; tick at terminal count. Per tick each tone counter decrements; at 0 it reloads tone[ch] and toggles tone_out[ch]. tone[ch]=0 or 1: tone_out held 1, counter held 0.
- noise_ctl[1:0] rate: 0->reload 16, 1->32, 2->64, 3->clocked by toggles of tone channel NUM_TONE-1. Noise divider toggles an internal flop; LFSR shifts right on each 0->1 of that flop.
- Shift-in bit: noise_ctl[2]=1 white: ^(LFSR & LFSR_TAPS); =0 periodic: LFSR[0].
- Reset values: READY=1, tone_out=0, noise_out=0, vol_out all 4'hF, tone regs 0, noise_ctl 0, LFSR=seed, latched ch=0 type=0, prescaler and counters 0.

## Timing
- Register update visible on outputs/counters the cycle after acceptance.
- READY low from cycle after acceptance for exactly WAIT_CYC cycles, then high.
- New tone value takes effect at next reload; in-flight count not disturbed.
- Tone write and tick same cycle: counter uses old value this tick.
- Noise write and LFSR shift same cycle: reseed wins, shift lost.
- nRST low at any point: all state to reset values immediately, independent of CLK; a write in progress is lost.
- Tone frequency = f_CLK / (2*PRESCALE*tone) for tone>=2.

## Test plan
- Reset: assert nRST mid-run -> READY=1, vol_out all F, tone_out=0, LFSR=seed without a CLK edge.
- Write 8'h8E then 8'h0F (ch0 tone=0x0FE) -> tone_out[0] toggles every 254*PRESCALE cycles; READY low WAIT_CYC cycles after each byte.
- Write 8'h95 -> vol_out[3:0]=5; then data 8'h03 -> vol_out[3:0]=3, tone0 unchanged.
- Hold wr low 10 cycles, and pulse wr while READY=0 -> exactly one write accepted.
- Write 8'hE4 (white, rate 16) -> LFSR reseeds, noise_out sequence matches model; then 8'hE0 -> periodic pattern with period LFSR_W shifts.
- NUM_TONE=2: write 8'hC5 -> no register changes; 8'hE7 -> noise clocked by tone1 toggles.
